// File: rtl/kern_buf_pkg.sv
// Shared constants, FSM state encodings and the configuration legality check
// for the kernel weight buffer.
package kern_buf_pkg;

   localparam int DATA_W    = 16;
   localparam int WGT_DEPTH = 1024;
   localparam int WADDR_W   = 10;
   localparam int MAX_KERN  = 64;
   localparam int KIDX_W    = 6;
   localparam int CFG_W     = 10;
   localparam int PERK_W    = 16;
   localparam int TOT_W     = 26;

   localparam logic [1:0] ST_IDLE  = 2'd0;
   localparam logic [1:0] ST_LOAD  = 2'd1;
   localparam logic [1:0] ST_READY = 2'd2;
   localparam logic [1:0] ST_SERVE = 2'd3;

   // Weights per kernel, F*S*S; operands widened first so the product cannot wrap.
   function automatic logic [PERK_W-1:0] calc_perk(input logic [CFG_W-1:0] f,
                                                   input logic [2:0]       s);
      return PERK_W'(f) * PERK_W'(s) * PERK_W'(s);
   endfunction

   function automatic logic cfg_legal(input logic [CFG_W-1:0] f,
                                      input logic [CFG_W-1:0] k,
                                      input logic [2:0]       s);
      logic [TOT_W-1:0] total;
      total = TOT_W'(calc_perk(f, s)) * TOT_W'(k);
      return (f != '0) && (k != '0) && (s != '0) &&
             (k <= CFG_W'(MAX_KERN)) && (total <= TOT_W'(WGT_DEPTH));
   endfunction

endpackage

// File: rtl/kern_weight_buffer_if.sv
// Kernel stream input and replay output bundle between the kernel reader,
// the weight buffer and the MAC datapath.
interface kern_weight_buffer_if;
   import kern_buf_pkg::*;

   logic [DATA_W-1:0] KERN_IN;
   logic              KERN_IN_VLD;
   logic              rd_start;
   logic [KIDX_W-1:0] rd_kern;
   logic [DATA_W-1:0] BIAS_OUT;
   logic [DATA_W-1:0] WGT_OUT;
   logic              WGT_VLD;
   logic              RD_DONE;
   logic              RD_ERR;

   modport slave (
      input  KERN_IN, KERN_IN_VLD, rd_start, rd_kern,
      output BIAS_OUT, WGT_OUT, WGT_VLD, RD_DONE, RD_ERR
   );

   modport master (
      output KERN_IN, KERN_IN_VLD, rd_start, rd_kern,
      input  BIAS_OUT, WGT_OUT, WGT_VLD, RD_DONE, RD_ERR
   );
endinterface

// File: rtl/kbuf_sp_ram.sv
// Single-port synchronous RAM, one-cycle read latency; the read register holds
// its value when no read is issued.
module kbuf_sp_ram #(
   parameter int DEPTH = 1024,
   parameter int AW    = 10,
   parameter int DW    = 16
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          we,
   input  logic          re,
   input  logic [AW-1:0] addr,
   input  logic [DW-1:0] wdata,
   output logic [DW-1:0] rdata
);

   logic [DW-1:0] mem [DEPTH];
   logic [DW-1:0] rdata_q, rdata_d;

   always_comb begin
      rdata_d = re ? mem[addr] : rdata_q;
   end

   // NOTE: the storage array is never reset; only the read register is cleared.
   always_ff @(posedge clk) begin
      if (we) mem[addr] <= wdata;
   end

   always_ff @(posedge clk) begin
      if (rst) rdata_q <= '0;
      else     rdata_q <= rdata_d;
   end

   assign rdata = rdata_q;

endmodule

// File: rtl/kern_weight_buffer.sv
// Captures a per-kernel bias+weight stream into on-chip RAMs, then replays one
// kernel's bias and weights on request.
module kern_weight_buffer
   import kern_buf_pkg::*;
(
   input  logic                clk,
   input  logic                rst,
   input  logic                op_start,
   input  logic [CFG_W-1:0]    CFG_NUM_FMAP,
   input  logic [CFG_W-1:0]    CFG_NUM_KERN,
   input  logic [2:0]          CFG_KERN_SIZE,
   kern_weight_buffer_if.slave bus,
   output logic                BUF_READY,
   output logic                BUSY,
   output logic                CFG_ERR,
   output logic                OVF_ERR
);

   logic [1:0]         state_q, state_d;
   logic [CFG_W-1:0]   k_q, k_d;
   logic [PERK_W-1:0]  perk_q, perk_d;
   logic [PERK_W-1:0]  widx_q, widx_d;
   logic [PERK_W-1:0]  rcnt_q, rcnt_d;
   logic [KIDX_W-1:0]  kcnt_q, kcnt_d;
   logic [KIDX_W-1:0]  kidx_q, kidx_d;
   logic [WADDR_W-1:0] addr_q, addr_d;
   logic               buf_ready_q, buf_ready_d;
   logic               cfg_err_q, cfg_err_d;
   logic               ovf_err_q, ovf_err_d;
   logic               wgt_vld_q, wgt_vld_d;
   logic               rd_done_q, rd_done_d;
   logic               rd_err_q, rd_err_d;

   logic               wgt_we, wgt_re, bias_we, bias_re;
   logic [PERK_W-1:0]  base_full;
   logic [KIDX_W-1:0]  bias_addr;

   // One shared address counter: running write pointer during load, read pointer during serve.
   assign base_full = PERK_W'(bus.rd_kern) * perk_q;
   assign bias_addr = (state_q == ST_LOAD) ? kcnt_q : kidx_q;

   // NOTE: every signal gets a default first so no path leaves it unassigned (no latches).
   always_comb begin
      state_d     = state_q;
      k_d         = k_q;
      perk_d      = perk_q;
      widx_d      = widx_q;
      rcnt_d      = rcnt_q;
      kcnt_d      = kcnt_q;
      kidx_d      = kidx_q;
      addr_d      = addr_q;
      buf_ready_d = buf_ready_q;
      cfg_err_d   = cfg_err_q;
      ovf_err_d   = ovf_err_q;
      wgt_vld_d   = 1'b0;
      rd_done_d   = 1'b0;
      rd_err_d    = 1'b0;
      wgt_we      = 1'b0;
      wgt_re      = 1'b0;
      bias_we     = 1'b0;
      bias_re     = 1'b0;

      if (op_start) begin
         k_d         = CFG_NUM_KERN;
         perk_d      = calc_perk(CFG_NUM_FMAP, CFG_KERN_SIZE);
         widx_d      = '0;
         rcnt_d      = '0;
         kcnt_d      = '0;
         addr_d      = '0;
         buf_ready_d = 1'b0;
         cfg_err_d   = 1'b0;
         ovf_err_d   = 1'b0;
         if (cfg_legal(CFG_NUM_FMAP, CFG_NUM_KERN, CFG_KERN_SIZE)) begin
            state_d = ST_LOAD;
         end else begin
            state_d   = ST_IDLE;
            cfg_err_d = 1'b1;
         end
      end else begin
         case (state_q)
            ST_LOAD: begin
               if (bus.KERN_IN_VLD) begin
                  if (widx_q == '0) begin
                     bias_we = 1'b1;
                     widx_d  = PERK_W'(1);
                  end else begin
                     wgt_we = 1'b1;
                     addr_d = addr_q + WADDR_W'(1);
                     if (widx_q == perk_q) begin
                        widx_d = '0;
                        if (CFG_W'(kcnt_q) == k_q - CFG_W'(1)) begin
                           state_d     = ST_READY;
                           buf_ready_d = 1'b1;
                        end else begin
                           kcnt_d = kcnt_q + KIDX_W'(1);
                        end
                     end else begin
                        widx_d = widx_q + PERK_W'(1);
                     end
                  end
               end
            end
            ST_READY: begin
               if (bus.rd_start) begin
                  if (CFG_W'(bus.rd_kern) >= k_q) begin
                     rd_err_d = 1'b1;
                  end else begin
                     state_d = ST_SERVE;
                     kidx_d  = bus.rd_kern;
                     addr_d  = base_full[WADDR_W-1:0];
                     rcnt_d  = '0;
                  end
               end
            end
            ST_SERVE: begin
               // The cycle showing the last weight still counts as SERVE.
               if (rd_done_q) begin
                  state_d = ST_READY;
               end else begin
                  wgt_re    = 1'b1;
                  bias_re   = (rcnt_q == '0);
                  addr_d    = addr_q + WADDR_W'(1);
                  rcnt_d    = rcnt_q + PERK_W'(1);
                  wgt_vld_d = 1'b1;
                  rd_done_d = (rcnt_q == perk_q - PERK_W'(1));
               end
            end
            default: ;
         endcase

         if (bus.KERN_IN_VLD && state_q != ST_LOAD) ovf_err_d = 1'b1;
         if (bus.rd_start && state_q != ST_READY)   rd_err_d  = 1'b1;
      end
   end

   // NOTE: sequential state uses non-blocking assignments only.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= ST_IDLE;
         k_q         <= '0;
         perk_q      <= '0;
         widx_q      <= '0;
         rcnt_q      <= '0;
         kcnt_q      <= '0;
         kidx_q      <= '0;
         addr_q      <= '0;
         buf_ready_q <= 1'b0;
         cfg_err_q   <= 1'b0;
         ovf_err_q   <= 1'b0;
         wgt_vld_q   <= 1'b0;
         rd_done_q   <= 1'b0;
         rd_err_q    <= 1'b0;
      end else begin
         state_q     <= state_d;
         k_q         <= k_d;
         perk_q      <= perk_d;
         widx_q      <= widx_d;
         rcnt_q      <= rcnt_d;
         kcnt_q      <= kcnt_d;
         kidx_q      <= kidx_d;
         addr_q      <= addr_d;
         buf_ready_q <= buf_ready_d;
         cfg_err_q   <= cfg_err_d;
         ovf_err_q   <= ovf_err_d;
         wgt_vld_q   <= wgt_vld_d;
         rd_done_q   <= rd_done_d;
         rd_err_q    <= rd_err_d;
      end
   end

   kbuf_sp_ram #(.DEPTH(WGT_DEPTH), .AW(WADDR_W), .DW(DATA_W)) u_wgt_ram (
      .clk   (clk),
      .rst   (rst),
      .we    (wgt_we),
      .re    (wgt_re),
      .addr  (addr_q),
      .wdata (bus.KERN_IN),
      .rdata (bus.WGT_OUT)
   );

   kbuf_sp_ram #(.DEPTH(MAX_KERN), .AW(KIDX_W), .DW(DATA_W)) u_bias_ram (
      .clk   (clk),
      .rst   (rst),
      .we    (bias_we),
      .re    (bias_re),
      .addr  (bias_addr),
      .wdata (bus.KERN_IN),
      .rdata (bus.BIAS_OUT)
   );

   assign bus.WGT_VLD = wgt_vld_q;
   assign bus.RD_DONE = rd_done_q;
   assign bus.RD_ERR  = rd_err_q;
   assign BUF_READY   = buf_ready_q;
   assign BUSY        = (state_q == ST_LOAD) || (state_q == ST_SERVE);
   assign CFG_ERR     = cfg_err_q;
   assign OVF_ERR     = ovf_err_q;

endmodule

// File: tb/tb_kern_weight_buffer.sv
// Directed bench for kern_weight_buffer: loads, replays against a queue of
// expected weights, and exercises the error and abort paths.
module tb_kern_weight_buffer;
   import kern_buf_pkg::*;

   logic             clk = 1'b0;
   logic             rst;
   logic             op_start;
   logic [CFG_W-1:0] cfg_f, cfg_k;
   logic [2:0]       cfg_s;
   logic             buf_ready, busy, cfg_err, ovf_err;

   int checks = 0;
   int errors = 0;
   logic [DATA_W-1:0] exp_q [$];

   kern_weight_buffer_if bus ();

   kern_weight_buffer dut (
      .clk           (clk),
      .rst           (rst),
      .op_start      (op_start),
      .CFG_NUM_FMAP  (cfg_f),
      .CFG_NUM_KERN  (cfg_k),
      .CFG_KERN_SIZE (cfg_s),
      .bus           (bus),
      .BUF_READY     (buf_ready),
      .BUSY          (busy),
      .CFG_ERR       (cfg_err),
      .OVF_ERR       (ovf_err)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
      checks++;
      assert (obs === exp_v) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp_v);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic start(input int f, input int k, input int s);
      cfg_f    = CFG_W'(f);
      cfg_k    = CFG_W'(k);
      cfg_s    = 3'(s);
      op_start = 1'b1;
      tick();
      op_start = 1'b0;
   endtask

   task automatic send_word(input logic [DATA_W-1:0] w);
      bus.KERN_IN     = w;
      bus.KERN_IN_VLD = 1'b1;
      tick();
      bus.KERN_IN_VLD = 1'b0;
   endtask

   task automatic check_reset(input string tag);
      check({tag, "_flags"}, 32'({buf_ready, busy, cfg_err, ovf_err,
                                  bus.WGT_VLD, bus.RD_DONE, bus.RD_ERR}), 32'd0);
      check({tag, "_bias"}, 32'(bus.BIAS_OUT), 32'd0);
      check({tag, "_wgt"},  32'(bus.WGT_OUT),  32'd0);
   endtask

   // Two kernels of 18 weights: kernel k has bias (k+1)*0x1000, weights k*0x100 + 1..18.
   task automatic stream(input bit gapped);
      logic [DATA_W-1:0] w;
      for (int kk = 0; kk < 2; kk++) begin
         for (int i = 0; i <= 18; i++) begin
            w = (i == 0) ? 16'((kk + 1) * 16'h1000) : 16'(kk * 16'h100 + i);
            if (kk == 1 && i == 18) check("buf_ready_before_last", 32'(buf_ready), 32'd0);
            send_word(w);
            if (kk == 1 && i == 18) check("buf_ready_after_last", 32'(buf_ready), 32'd1);
            if (gapped) tick();
         end
      end
   endtask

   task automatic replay(input logic [KIDX_W-1:0] kidx, input logic [DATA_W-1:0] bias_v,
                         input logic [DATA_W-1:0] wbase);
      logic [DATA_W-1:0] e;
      for (int i = 1; i <= 18; i++) exp_q.push_back(wbase + DATA_W'(i));
      bus.rd_kern  = kidx;
      bus.rd_start = 1'b1;
      tick();
      bus.rd_start = 1'b0;
      check("vld_not_early", 32'(bus.WGT_VLD), 32'd0);
      tick();
      check("bias_out", 32'(bus.BIAS_OUT), 32'(bias_v));
      for (int c = 0; c < 24 && exp_q.size() != 0; c++) begin
         if (bus.WGT_VLD !== 1'b1) begin
            check("wgt_vld_contig", 32'(bus.WGT_VLD), 32'd1);
            exp_q.delete();
         end else begin
            e = exp_q.pop_front();
            check("wgt_out", 32'(bus.WGT_OUT), 32'(e));
            check("rd_done", 32'(bus.RD_DONE), 32'(exp_q.size() == 0));
            tick();
         end
      end
      check("replay_drained", 32'(exp_q.size()), 32'd0);
      check("vld_after_replay", 32'(bus.WGT_VLD), 32'd0);
      check("busy_after_replay", 32'(busy), 32'd0);
   endtask

   initial begin
      logic seen;
      rst             = 1'b1;
      op_start        = 1'b0;
      cfg_f           = '0;
      cfg_k           = '0;
      cfg_s           = '0;
      bus.KERN_IN     = '0;
      bus.KERN_IN_VLD = 1'b0;
      bus.rd_start    = 1'b0;
      bus.rd_kern     = '0;
      tick();
      tick();
      check_reset("reset");
      rst = 1'b0;
      tick();

      // Full load, then replay kernel 1
      start(2, 2, 3);
      check("busy_load", 32'(busy), 32'd1);
      check("ready_load", 32'(buf_ready), 32'd0);
      stream(1'b0);
      check("busy_ready", 32'(busy), 32'd0);
      replay(6'd1, 16'h2000, 16'h0100);

      // Out-of-range kernel index
      bus.rd_kern  = 6'd2;
      bus.rd_start = 1'b1;
      tick();
      bus.rd_start = 1'b0;
      check("rd_err_pulse", 32'(bus.RD_ERR), 32'd1);
      check("rd_err_no_vld", 32'(bus.WGT_VLD), 32'd0);
      tick();
      check("rd_err_clears", 32'(bus.RD_ERR), 32'd0);
      check("rd_err_no_vld2", 32'(bus.WGT_VLD), 32'd0);

      // Extra stream word
      send_word(16'hDEAD);
      check("ovf_set", 32'(ovf_err), 32'd1);
      check("ovf_ready_kept", 32'(buf_ready), 32'd1);
      replay(6'd1, 16'h2000, 16'h0100);
      replay(6'd0, 16'h1000, 16'h0000);

      // Gapped stream
      start(2, 2, 3);
      check("ovf_cleared", 32'(ovf_err), 32'd0);
      stream(1'b1);
      replay(6'd0, 16'h1000, 16'h0000);

      // Config rejection
      start(8, 16, 3);
      check("cfg_err_size", 32'(cfg_err), 32'd1);
      check("cfg_err_not_ready", 32'(buf_ready), 32'd0);
      check("cfg_err_idle", 32'(busy), 32'd0);
      for (int i = 0; i < 5; i++) send_word(16'(16'h0F00 + i));
      check("cfg_err_words_dropped", 32'(buf_ready), 32'd0);
      check("cfg_err_ovf", 32'(ovf_err), 32'd1);
      bus.rd_kern  = 6'd0;
      bus.rd_start = 1'b1;
      tick();
      bus.rd_start = 1'b0;
      check("rd_err_idle", 32'(bus.RD_ERR), 32'd1);
      start(2, 0, 3);
      check("cfg_err_k0", 32'(cfg_err), 32'd1);
      start(2, 2, 3);
      check("cfg_err_cleared", 32'(cfg_err), 32'd0);
      check("cfg_ok_busy", 32'(busy), 32'd1);

      // Reset after 10 loaded words, then full reload
      for (int i = 0; i < 10; i++) send_word(16'(16'h0A00 + i));
      rst = 1'b1;
      tick();
      check_reset("midload_reset");
      rst = 1'b0;
      tick();
      start(2, 2, 3);
      stream(1'b0);
      replay(6'd1, 16'h2000, 16'h0100);

      // op_start during the 5th weight of a replay
      bus.rd_kern  = 6'd0;
      bus.rd_start = 1'b1;
      tick();
      bus.rd_start = 1'b0;
      repeat (5) tick();
      check("abort_fifth_vld", 32'(bus.WGT_VLD), 32'd1);
      check("abort_fifth_wgt", 32'(bus.WGT_OUT), 32'h0005);
      start(2, 2, 3);
      check("abort_vld_drop", 32'(bus.WGT_VLD), 32'd0);
      check("abort_no_done", 32'(bus.RD_DONE), 32'd0);
      check("abort_busy_load", 32'(busy), 32'd1);
      check("abort_not_ready", 32'(buf_ready), 32'd0);
      seen = 1'b0;
      for (int i = 0; i < 20; i++) begin
         tick();
         seen = seen | bus.RD_DONE | bus.WGT_VLD;
      end
      check("abort_quiet", 32'(seen), 32'd0);
      check("abort_still_load", 32'(busy), 32'd1);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/kern_weight_buffer.md
Name: kern_weight_buffer

Overview:
- Sits directly downstream of the kernel reader.
- Captures the 16-bit kernel word stream (KERN_OUT/KERN_VLD) into on-chip weight and bias storage, organised per kernel.
- After a complete load, replays any one kernel's bias and weights to the convolution MAC datapath on request.
- Decouples DRAM kernel fetch from per-kernel compute reuse.

Parameters:
- DATA_W, 16, word width of weights and biases.
- WGT_DEPTH, 1024, weight RAM entries.
- WADDR_W, 10, log2(WGT_DEPTH).
- MAX_KERN, 64, bias entries and maximum CFG_NUM_KERN.
- KIDX_W, 6, log2(MAX_KERN).

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous, active-high reset.
- op_start  in  1  1-cycle pulse; latch cfg, start a new load.
- CFG_NUM_FMAP  in  10  input channels F.
- CFG_NUM_KERN  in  10  kernels K.
- CFG_KERN_SIZE  in  3  kernel side S (1..7).
- KERN_IN  in  DATA_W  stream word.
- KERN_IN_VLD  in  1  word valid; no backpressure, every valid word is consumed.
- rd_start  in  1  1-cycle pulse; replay kernel rd_kern.
- rd_kern  in  KIDX_W  kernel index.
- BIAS_OUT  out  DATA_W  bias of the kernel being replayed.
- WGT_OUT  out  DATA_W  weight word.
- WGT_VLD  out  1  WGT_OUT valid.
- RD_DONE  out  1  pulse with the last weight.
- RD_ERR  out  1  pulse: rd_start rejected.
- BUF_READY  out  1  load complete, idle for reads.
- BUSY  out  1  loading or serving.
- CFG_ERR  out  1  sticky; cleared by the next op_start.
- OVF_ERR  out  1  sticky; extra stream words seen; cleared by the next op_start.

Behaviour:
- Reset values:
  - All outputs 0; state IDLE.
  - Counters 0.
  - RAM contents are not reset.
- Stream order, per kernel k = 0..K-1: one bias word, then PERK = F*S*S weights, ordered fmap-major, then row, then column.
  - Total words = K*(PERK+1), which equals the reader's F*K*S*S + K.
- Widths:
  - PERK is 16 bits (max 1023*49 = 50127).
  - Total weights product is 26 bits.
  - Write addresses come from a running counter (no multiply on the write path).
  - Read base = rd_kern*PERK, truncated to WADDR_W; legal because the total is bounded by the config check.
- op_start, accepted in any state (overrides load/serve; aborts a replay with no RD_DONE):
  - Latch config; clear CFG_ERR and OVF_ERR.
  - If F==0, K==0, S==0, K>MAX_KERN, or F*K*S*S>WGT_DEPTH: set CFG_ERR, go to IDLE, drop stream words.
  - Otherwise go to LOAD with counters cleared and BUF_READY=0.
- LOAD, per KERN_IN_VLD:
  - At word index 0 within a kernel: write bias[kcnt].
  - Otherwise: write wgt[waddr] and increment waddr.
  - After word PERK of kernel K-1: BUF_READY=1 the next cycle and state becomes READY.
  - Gaps in VLD are allowed.
- KERN_IN_VLD in IDLE or READY: word dropped, OVF_ERR=1. BUF_READY is unaffected.
- READY, rd_start:
  - If rd_kern >= K: RD_ERR pulses next cycle and state stays READY.
  - Otherwise go to SERVE.
  - rd_start in any state other than READY: ignored, RD_ERR pulses.
- SERVE timing, with rd_start sampled at edge N:
  - Edge N: weight RAM address = base (synchronous 1-cycle RAM).
  - Edge N+1: BIAS_OUT updated (held until the next replay); WGT_VLD=1 with WGT_OUT = wgt[base].
  - Weights continue one per cycle, contiguous, for PERK cycles.
  - RD_DONE is high in the same cycle as the last WGT_VLD.
  - The next edge returns to READY, with WGT_VLD=0.
- BUSY = (state==LOAD || state==SERVE).
- Reset mid-load or mid-serve: everything returns to reset values; BUF_READY=0 until a full reload.
- rd_start and op_start in the same cycle: op_start wins; no RD_ERR.

Decomposition:
- Shared package kern_buf_pkg:
  - State enum IDLE/LOAD/READY/SERVE.
  - DATA_W, MAX_KERN, KIDX_W.
  - Config-check function returning a legal flag.
- One natural sub-module: kbuf_sp_ram, a single-port synchronous RAM with 1-cycle read latency, instantiated for weights (WGT_DEPTH) and bias (MAX_KERN).

Test Plan:
- Full load and replay:
  - Stimulus: F=2, K=2, S=3 (PERK=18). Stream 38 words: 0x1000, 0x0001..0x0012, 0x2000, 0x0101..0x0112. Then rd_start with rd_kern=1.
  - Required: BUF_READY=1 one cycle after word 38. BIAS_OUT=0x2000. WGT_OUT 0x0101..0x0112 on 18 consecutive cycles, the first 2 cycles after rd_start. RD_DONE on 0x0112.
- Gapped stream:
  - Stimulus: same config and data, with KERN_IN_VLD toggling 1-0-1.
  - Required: identical replay for rd_kern=0: bias 0x1000, weights 0x0001..0x0012.
- Config rejection:
  - Stimulus: F=8, K=16, S=3 (1152 > 1024).
  - Required: CFG_ERR=1, BUF_READY=0, streamed words ignored. A following op_start with legal config clears CFG_ERR.
- Errors:
  - Stimulus: rd_start with rd_kern=2 when K=2.
  - Required: RD_ERR pulse, no WGT_VLD.
  - Stimulus: a 39th stream word.
  - Required: OVF_ERR=1, stored data unchanged.
- Aborts:
  - Stimulus: rst after 10 loaded words.
  - Required: all outputs 0; a full reload then replays correctly.
  - Stimulus: op_start at the 5th weight of a replay.
  - Required: WGT_VLD drops next cycle, no RD_DONE, state LOAD.
